btn_counter_display: RTL

BTN_COUNTER_DISPLAY -- requirements
Module: btn_counter_display

---
 rtl/btn_counter_display.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/btn_counter_display.sv
// Button-driven up/down counter with freeze snapshot and a
// multiplexed seven-segment hex display.
module btn_counter_display #(
    parameter int COUNT_WIDTH     = 16,
    parameter int COUNT_INC       = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 100000,
    parameter int DIGITS          = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            SW,
    input  logic [4:0]             BTN,
    output logic [COUNT_WIDTH-1:0] LED,
    output logic [6:0]             HEX,
    output logic                   DP,
    output logic [DIGITS-1:0]      AN
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int LIVE   = COUNT_WIDTH / 4;
    localparam logic [COUNT_WIDTH-1:0] STEP = COUNT_WIDTH'(COUNT_INC);

    logic [4:0]            sync1;
    logic [4:0]            sync2;
    logic [4:0]            level;
    logic [4:0]            level_d;
    logic [4:0]            press;
    logic [4:0][DB_W-1:0]  mis_cnt;

    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] snapshot;
    logic [COUNT_WIDTH-1:0] sw_val;
    logic                   frozen;

    logic [SCAN_W-1:0]      scan;
    logic [IDX_W-1:0]       digit_idx;
    logic [DIGITS*4-1:0]    disp_pad;
    logic [3:0]             nibble;
    logic [DIGITS-1:0]      an_q;
    logic [6:0]             hex_q;

    generate
        if (COUNT_WIDTH > 16) begin : g_sw_ext
            assign sw_val = {{(COUNT_WIDTH-16){1'b0}}, SW};
        end else begin : g_sw_trunc
            assign sw_val = SW[COUNT_WIDTH-1:0];
        end
    endgenerate

    // A level change is accepted only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            mis_cnt <= '0;
        end else begin
            sync1   <= BTN;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == level[i]) begin
                    mis_cnt[i] <= '0;
                end else if (mis_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]   <= sync2[i];
                    mis_cnt[i] <= '0;
                end else begin
                    mis_cnt[i] <= mis_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press = level & ~level_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            snapshot <= '0;
            frozen   <= 1'b0;
        end else begin
            if (press[3]) begin
                count <= '0;
            end else if (press[2]) begin
                count <= sw_val;
            end else if (press[0] && !press[1]) begin
                count <= count + STEP;
            end else if (press[1] && !press[0]) begin
                count <= count - STEP;
            end
            if (press[4]) begin
                frozen <= ~frozen;
                if (!frozen) begin
                    snapshot <= count;
                end
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    assign disp_pad = (DIGITS*4)'(frozen ? snapshot : count);
    assign nibble   = disp_pad[digit_idx*4 +: 4];

    // Segment drive is registered from the current index, so AN/HEX
    // switch together one cycle after the index moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan      <= '0;
            digit_idx <= '0;
            an_q      <= '1;
            hex_q     <= 7'h7F;
        end else begin
            if (scan == SCAN_W'(SCAN_DIV - 1)) begin
                scan <= '0;
                if (digit_idx == IDX_W'(DIGITS - 1)) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + IDX_W'(1);
                end
            end else begin
                scan <= scan + SCAN_W'(1);
            end
            if (int'(digit_idx) >= LIVE) begin
                an_q  <= '1;
                hex_q <= 7'h7F;
            end else begin
                an_q  <= ~(DIGITS'(1) << digit_idx);
                hex_q <= glyph(nibble);
            end
        end
    end

    assign LED = count;
    assign AN  = an_q;
    assign HEX = hex_q;
    assign DP  = 1'b1;

endmodule
